// File: rtl/cipher_nibble_packer_if.sv
// Handshake bundle between the nibble producer/word consumer and the packer.
// The packer takes the slave view; the surrounding logic takes the master view.
interface cipher_nibble_packer_if #(
  parameter int N = 4
);
  localparam int LW = $clog2(N) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    encrypt_data;
  logic [3:0]    private_key;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [4*N-1:0] out_word;
  logic [LW-1:0] out_len;
  logic [3:0]    out_chk;
  logic [3:0]    out_key;

  modport master (
    output in_valid, encrypt_data, private_key, flush, out_ready,
    input  in_ready, out_valid, out_word, out_len, out_chk, out_key
  );

  modport slave (
    input  in_valid, encrypt_data, private_key, flush, out_ready,
    output in_ready, out_valid, out_word, out_len, out_chk, out_key
  );
endinterface

// File: rtl/cipher_nibble_packer.sv
// Packs N encrypted nibbles into one word with an XOR checksum and a key digest,
// presenting each closed word on a valid/ready port with no bubble between words.
module cipher_nibble_packer #(
  parameter int         N        = 4,
  parameter logic [3:0] CHK_INIT = 4'h0
) (
  input logic clk,
  input logic rst,
  cipher_nibble_packer_if.slave bus
);
  localparam int LW = $clog2(N) + 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [N-1:0][3:0]    word_reg, word_next;
  logic [LW-1:0]        cnt_reg, cnt_next;
  logic [3:0]           chk_reg, chk_next;
  logic [3:0]           key_reg, key_next;
  logic                 accept;
  logic                 close;

  logic                 out_valid_reg;
  logic [4*N-1:0]       out_word_reg;
  logic [LW-1:0]        out_len_reg;
  logic [3:0]           out_chk_reg;
  logic [3:0]           out_key_reg;

  // HOLD only admits a nibble when the held word leaves in the same cycle.
  assign bus.in_ready = !rst && ((state_reg == FILL) || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign word_next[gi] = (accept && (cnt_reg == LW'(gi))) ? bus.encrypt_data
                                                              : word_reg[gi];
    end
  endgenerate

  // The accumulators are cleared whenever a word closes, so in HOLD they already
  // describe an empty word and a fresh nibble simply lands in slot 0.
  always_comb begin
    cnt_next = cnt_reg + LW'(accept);
    chk_next = chk_reg ^ (accept ? bus.encrypt_data : 4'h0);
    key_next = key_reg ^ (accept ? bus.private_key : 4'h0);
    close    = (accept && (cnt_next == LW'(N))) || (bus.flush && (cnt_next != '0));
    if (close) begin
      state_next = HOLD;
    end else if ((state_reg == HOLD) && !bus.out_ready) begin
      state_next = HOLD;
    end else begin
      state_next = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      word_reg      <= '0;
      cnt_reg       <= '0;
      chk_reg       <= CHK_INIT;
      key_reg       <= 4'h0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
      out_len_reg   <= '0;
      out_chk_reg   <= CHK_INIT;
      out_key_reg   <= 4'h0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next == HOLD);
      if (close) begin
        out_word_reg <= word_next;
        out_len_reg  <= cnt_next;
        out_chk_reg  <= chk_next;
        out_key_reg  <= key_next;
        word_reg     <= '0;
        cnt_reg      <= '0;
        chk_reg      <= CHK_INIT;
        key_reg      <= 4'h0;
      end else begin
        word_reg     <= word_next;
        cnt_reg      <= cnt_next;
        chk_reg      <= chk_next;
        key_reg      <= key_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_word  = out_word_reg;
  assign bus.out_len   = out_len_reg;
  assign bus.out_chk   = out_chk_reg;
  assign bus.out_key   = out_key_reg;
endmodule

// File: doc/cipher_nibble_packer.md
# cipher_nibble_packer

Downstream packing stage for the hexadecimal encrypt/decrypt datapath. It accepts one 4-bit encrypted nibble per transfer, together with the 4-bit private key produced for that nibble. It packs N nibbles into one word and adds an XOR checksum and a cumulative key digest. It then presents the word on a valid/ready output port to the transport or storage stage.

## Interface
- N, default 4: nibbles per word; legal range 2..8.
- CHK_INIT, default 4'h0: seed XORed into every checksum.
- LW, derived = $clog2(N)+1: width of out_len.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  encrypt_data/private_key valid.
- in_ready  out  1  block can accept a nibble this cycle.
- encrypt_data  in  4  encrypted nibble from the encryption stage.
- private_key  in  4  private key accompanying the nibble.
- flush  in  1  close the current partial word.
- out_valid  out  1  out_word/out_len/out_chk/out_key valid.
- out_ready  in  1  consumer accepts the word this cycle.
- out_word  out  4*N  packed nibbles; slot k = out_word[4k+3:4k]; slot 0 is the first nibble accepted.
- out_len  out  LW  number of real nibbles in out_word, 1..N.
- out_chk  out  4  CHK_INIT ^ XOR of all N slots (pad slots count as 0).
- out_key  out  4  XOR of the private_key of every accepted nibble in the word.

## Operation
- Accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Two states: FILL (assembling a word) and HOLD (word presented).
- FILL:
  - in_ready=1 and out_valid=0.
  - On accept, the nibble is written to slot cnt, cnt increments, and the nibble is XORed into the running chk and its private_key into the running key.
  - Word close condition: the accept fills slot N-1, or flush=1 with at least one nibble in the word after this cycle's accept.
  - On close: register out_word, out_len, out_chk and out_key; go to HOLD.
  - flush with cnt=0 and no accept is ignored.
  - flush and an accept in the same cycle: the nibble is included, then the word closes.
- HOLD:
  - out_valid=1 and in_ready=out_ready.
  - out_ready=0: all outputs hold stable; no accept; flush ignored.
  - out_ready=1, no accept: go to FILL with cnt=0 and accumulators cleared (chk=CHK_INIT, key=0).
  - out_ready=1 with an accept: the nibble starts a fresh word in slot 0, cnt becomes 1, and the accumulators are reseeded with this nibble.
  - In that same cycle, flush=1 closes the new 1-nibble word and the block stays in HOLD.
- Unused slots of a flushed word are 4'h0.
- Reset, including mid-word or in HOLD: any partial word and any held word are discarded.
- Reset values: state FILL, cnt=0, out_valid=0, out_word=0, out_len=0, out_chk=CHK_INIT, out_key=0.
- in_ready=0 during any cycle where rst=1.

## Timing
- out_valid rises in the cycle after the closing accept or flush (1-cycle latency).
- Sustained throughput is one nibble per clock when out_ready stays high: the HOLD cycle accepts the next word's first nibble, so there is no bubble.
- in_ready is a function of state and out_ready only, never of in_valid.
- out_* change only on entry to HOLD, and are stable for every cycle out_valid=1 && out_ready=0.

## Test plan
- Streaming word: after reset, N=4, CHK_INIT=0, out_ready=1. Send nibbles 1,2,3,4 with keys 1,2,4,8 on cycles 1-4. Expect out_valid on cycle 5 with out_word=16'h4321, out_len=3'd4, out_chk=4'h4, out_key=4'hF.
- Back-to-back: 8 consecutive nibbles with out_ready=1. Expect in_ready high throughout and out_valid pulses on cycles 5 and 9, with no bubble.
- Backpressure: word held with out_ready=0 for 5 cycles. Expect in_ready=0 and outputs unchanged. Then raise out_ready with in_valid carrying 7: transfer completes and the next word's slot 0 is 4'h7.
- Flush partial: send 9 then 6, then flush. Expect out_word=16'h0069, out_len=2, out_chk=4'hF.
  - flush with cnt=0 produces no out_valid.
  - Nibbles 1,2 then 3 together with flush: expect out_word=16'h0321, out_len=3, out_chk=4'h0.
- Reset mid-word: after 3 accepted nibbles assert rst for 1 cycle. Expect out_valid=0 and in_ready=0 during reset. Then 4 new nibbles A,B,C,D give out_word=16'hDCBA, out_chk=4'h0, with no residue from the discarded nibbles.
